// File: rtl/timer_a_periph.sv
// Timer_A style peripheral: control/status registers on the CPU bus, a 16-bit
// counter with a 1/2/4/8 prescaler, stop/up/continuous/up-down modes, one
// compare register (CCR0) and a level interrupt request.
module timer_a_periph #(
  parameter logic [15:0] TA_BASE = 16'h0160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] MAB_in,
  input  logic [15:0] MDB_in,
  input  logic        MW,
  input  logic        BW,
  output logic        TA_sel,
  output logic [15:0] TA_rdata,
  output logic        irq,
  input  logic        irq_ack
);

  typedef enum logic [1:0] {
    MC_STOP = 2'b00,
    MC_UP   = 2'b01,
    MC_CONT = 2'b10,
    MC_UPDN = 2'b11
  } mc_e;

  localparam logic [15:0] ADDR_CTL  = TA_BASE;
  localparam logic [15:0] ADDR_CCTL = TA_BASE + 16'd2;
  localparam logic [15:0] ADDR_TAR  = TA_BASE + 16'd16;
  localparam logic [15:0] ADDR_CCR0 = TA_BASE + 16'd18;

  // Register state
  logic [1:0]  id_q, id_d;
  mc_e         mc_q, mc_d;
  logic        taie_q, taie_d;
  logic        taifg_q, taifg_d;
  logic        ccie_q, ccie_d;
  logic        ccifg_q, ccifg_d;
  logic [15:0] tar_q, tar_d;
  logic [15:0] taccr0_q, taccr0_d;
  logic [2:0]  presc_q, presc_d;
  logic        dir_down_q, dir_down_d;

  // Bus decode and readback
  logic [15:0] addr_w;
  logic        sel_ctl, sel_cctl, sel_tar, sel_ccr0;
  logic [15:0] ctl_rd, cctl_rd;
  logic        wr_ctl, wr_cctl, wr_tar, wr_ccr0;
  logic [15:0] ctl_wd, cctl_wd, tar_wd, ccr0_wd;

  // Counter engine
  logic [2:0]  presc_limit;
  logic        running, tick;
  logic [15:0] tar_inc, tar_dec;
  logic [15:0] cnt_nxt;
  logic        dir_nxt;
  logic        cc_hit, wrap_hit;
  logic        up_phase;
  logic        cc_set, tai_set;

  // Merge CPU write data into an existing register image (word or byte lane).
  function automatic logic [15:0] merge_wr(input logic [15:0] old_val,
                                           input logic [15:0] wdata,
                                           input logic        byte_acc,
                                           input logic        hi_byte);
    if (!byte_acc)    merge_wr = wdata;
    else if (hi_byte) merge_wr = {wdata[7:0], old_val[7:0]};
    else              merge_wr = {old_val[15:8], wdata[7:0]};
  endfunction

  assign addr_w   = {MAB_in[15:1], 1'b0};
  assign sel_ctl  = (addr_w == ADDR_CTL);
  assign sel_cctl = (addr_w == ADDR_CCTL);
  assign sel_tar  = (addr_w == ADDR_TAR);
  assign sel_ccr0 = (addr_w == ADDR_CCR0);
  assign TA_sel   = sel_ctl | sel_cctl | sel_tar | sel_ccr0;

  // TACLR (bit 2) is an action bit, so it never reads back.
  assign ctl_rd  = {8'h00, id_q, mc_q, 2'b00, taie_q, taifg_q};
  assign cctl_rd = {11'd0, ccie_q, 3'd0, ccifg_q};

  assign wr_ctl  = MW & sel_ctl;
  assign wr_cctl = MW & sel_cctl;
  assign wr_tar  = MW & sel_tar;
  assign wr_ccr0 = MW & sel_ccr0;

  assign ctl_wd  = merge_wr(ctl_rd,   MDB_in, BW, MAB_in[0]);
  assign cctl_wd = merge_wr(cctl_rd,  MDB_in, BW, MAB_in[0]);
  assign tar_wd  = merge_wr(tar_q,    MDB_in, BW, MAB_in[0]);
  assign ccr0_wd = merge_wr(taccr0_q, MDB_in, BW, MAB_in[0]);

  // Register bits that have no storage behind them.
  logic unused_wd_bits;
  assign unused_wd_bits = ^{ctl_wd[15:8], ctl_wd[3], cctl_wd[15:5], cctl_wd[3:1]};

  // Combinational read mux; whole aligned word, zero when not addressed.
  always_comb begin
    TA_rdata = 16'h0000;
    if (sel_ctl)  TA_rdata = ctl_rd;
    if (sel_cctl) TA_rdata = cctl_rd;
    if (sel_tar)  TA_rdata = tar_q;
    if (sel_ccr0) TA_rdata = taccr0_q;
  end

  assign irq = (ccie_q & ccifg_q) | (taie_q & taifg_q);

  // Prescaler tick: counts 0..2^ID-1 while running; >= copes with ID shrinking mid-count.
  assign presc_limit = 3'((4'd1 << id_q) - 4'd1);
  assign running     = (mc_q != MC_STOP);
  assign tick        = running && (presc_q >= presc_limit);
  assign tar_inc     = tar_q + 16'd1;
  assign tar_dec     = tar_q - 16'd1;
  // Up/down: a counter parked at 0 always restarts upward.
  assign up_phase    = (tar_q == 16'h0000) || (!dir_down_q && (tar_q < taccr0_q));

  // Counter step for one tick in the current mode, plus the events it causes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    cnt_nxt  = tar_q;
    dir_nxt  = dir_down_q;
    cc_hit   = 1'b0;
    wrap_hit = 1'b0;
    if (tick) begin
      unique case (mc_q)
        MC_UP: begin
          if (taccr0_q == 16'h0000) begin
            cnt_nxt = 16'h0000;
          end else if (tar_q == taccr0_q) begin
            cnt_nxt  = 16'h0000;
            wrap_hit = 1'b1;
          end else begin
            cnt_nxt  = tar_inc;
            cc_hit   = (tar_inc == taccr0_q);
            wrap_hit = (tar_q == 16'hFFFF);
          end
        end
        MC_CONT: begin
          cnt_nxt  = tar_inc;
          cc_hit   = (tar_inc == taccr0_q);
          wrap_hit = (tar_q == 16'hFFFF);
        end
        MC_UPDN: begin
          if (taccr0_q == 16'h0000) begin
            cnt_nxt = 16'h0000;
            dir_nxt = 1'b0;
          end else if (up_phase) begin
            cnt_nxt = tar_inc;
            dir_nxt = 1'b0;
            if (tar_inc == taccr0_q) begin
              cc_hit  = 1'b1;
              dir_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = tar_dec;
            dir_nxt = 1'b1;
            if (tar_dec == 16'h0000) begin
              wrap_hit = 1'b1;
              dir_nxt  = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state: counter update, then ack, then CPU writes, then hardware flag sets win.
  always_comb begin
    id_d       = id_q;
    mc_d       = mc_q;
    taie_d     = taie_q;
    taifg_d    = taifg_q;
    ccie_d     = ccie_q;
    ccifg_d    = ccifg_q;
    taccr0_d   = taccr0_q;
    tar_d      = cnt_nxt;
    dir_down_d = dir_nxt;
    presc_d    = presc_q;
    cc_set     = cc_hit;
    tai_set    = wrap_hit;

    if (running) presc_d = tick ? 3'd0 : presc_q + 3'd1;

    if (irq_ack) ccifg_d = 1'b0;

    if (wr_ctl) begin
      id_d    = ctl_wd[7:6];
      mc_d    = mc_e'(ctl_wd[5:4]);
      taie_d  = ctl_wd[1];
      taifg_d = ctl_wd[0];
      if (ctl_wd[2]) begin
        tar_d      = 16'h0000;
        presc_d    = 3'd0;
        dir_down_d = 1'b0;
        cc_set     = 1'b0;
        tai_set    = 1'b0;
      end
    end

    // A CPU write to TAR replaces this cycle's count step and its events.
    if (wr_tar) begin
      tar_d      = tar_wd;
      dir_down_d = dir_down_q;
      cc_set     = 1'b0;
      tai_set    = 1'b0;
    end

    if (wr_cctl) begin
      ccie_d  = cctl_wd[4];
      ccifg_d = cctl_wd[0];
    end

    if (wr_ccr0) taccr0_d = ccr0_wd;

    if (cc_set)  ccifg_d = 1'b1;
    if (tai_set) taifg_d = 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; every state bit is cleared, nothing left X.
    if (rst) begin
      id_q       <= 2'b00;
      mc_q       <= MC_STOP;
      taie_q     <= 1'b0;
      taifg_q    <= 1'b0;
      ccie_q     <= 1'b0;
      ccifg_q    <= 1'b0;
      tar_q      <= 16'h0000;
      taccr0_q   <= 16'h0000;
      presc_q    <= 3'd0;
      dir_down_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update together from pre-edge values.
      id_q       <= id_d;
      mc_q       <= mc_d;
      taie_q     <= taie_d;
      taifg_q    <= taifg_d;
      ccie_q     <= ccie_d;
      ccifg_q    <= ccifg_d;
      tar_q      <= tar_d;
      taccr0_q   <= taccr0_d;
      presc_q    <= presc_d;
      dir_down_q <= dir_down_d;
    end
  end

endmodule
